// File: rtl/tos_mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tos_mdu_pkg
// Brief    : Op codes and sequencer states shared by the TOS multiply/divide unit
// Revision : 1.0 - initial release
// ============================================================================
package tos_mdu_pkg;

    localparam logic [2:0] OP_UMUL    = 3'b000;
    localparam logic [2:0] OP_UDIVMOD = 3'b001;
    localparam logic [2:0] OP_LSL     = 3'b010;
    localparam logic [2:0] OP_LSR     = 3'b011;
    localparam logic [2:0] OP_ASR     = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage
`default_nettype wire

// File: rtl/tos_mdu_step.sv
`default_nettype none
// ============================================================================
// Module   : tos_mdu_step
// Brief    : One combinational iteration of shift-add multiply, restoring
//            divide, or single-bit shift
// Revision : 1.0 - initial release
// ============================================================================
module tos_mdu_step
    import tos_mdu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_operand,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_acc,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shl;
    logic [WIDTH:0] w_diff;

    always_comb begin
        // Multiply: acc:q holds the partial product, multiplier bits leave from q's LSB
        w_sum  = i_q[0] ? ({1'b0, i_acc} + {1'b0, i_operand}) : {1'b0, i_acc};
        // Divide: acc is the partial remainder, dividend bits enter from q's MSB
        w_shl  = {i_acc, i_q[WIDTH-1]};
        w_diff = w_shl - {1'b0, i_operand};
        o_acc  = i_acc;
        o_q    = i_q;
        case (i_op)
            OP_UMUL: begin
                o_acc = w_sum[WIDTH:1];
                o_q   = {w_sum[0], i_q[WIDTH-1:1]};
            end
            OP_UDIVMOD: begin
                if (!w_diff[WIDTH]) begin
                    o_acc = w_diff[WIDTH-1:0];
                    o_q   = {i_q[WIDTH-2:0], 1'b1};
                end else begin
                    o_acc = w_shl[WIDTH-1:0];
                    o_q   = {i_q[WIDTH-2:0], 1'b0};
                end
            end
            OP_LSL:  o_q = {i_q[WIDTH-2:0], 1'b0};
            OP_LSR:  o_q = {1'b0, i_q[WIDTH-1:1]};
            OP_ASR:  o_q = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/tos_mdu.sv
`default_nettype none
// ============================================================================
// Module   : tos_mdu
// Brief    : Iterative UM*, UM/MOD and N-bit shift unit beside the TOS ALU
// Revision : 1.0 - initial release
// ============================================================================
module tos_mdu
    import tos_mdu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] tos,
    input  logic [WIDTH-1:0] nos,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero,
    output logic             bad_op
);

    localparam logic [SHW:0] c_FULL = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] c_ONE  = (SHW+1)'(1);

    state_t           r_state;
    logic [SHW:0]     r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic             r_bad;

    logic [SHW:0]     w_steps;
    logic             w_dbz;
    logic             w_bad;
    logic [WIDTH-1:0] w_acc;
    logic [WIDTH-1:0] w_q;

    always_comb begin
        w_steps = '0;
        w_dbz   = 1'b0;
        w_bad   = 1'b0;
        case (op)
            OP_UMUL:    w_steps = c_FULL;
            OP_UDIVMOD: begin
                if (tos == '0) w_dbz   = 1'b1;
                else           w_steps = c_FULL;
            end
            OP_LSL, OP_LSR, OP_ASR: w_steps = {1'b0, tos[SHW-1:0]};
            default:    w_bad = 1'b1;
        endcase
    end

    tos_mdu_step #(
        .WIDTH     (WIDTH)
    ) u_step (
        .i_acc     (r_acc),
        .i_q       (r_q),
        .i_operand (r_operand),
        .i_op      (r_op),
        .o_acc     (w_acc),
        .o_q       (w_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_operand <= '0;
            r_lo      <= '0;
            r_hi      <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dbz     <= 1'b0;
            r_bad     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start && !abort) begin
                        r_op      <= op;
                        r_acc     <= '0;
                        r_q       <= nos;
                        r_operand <= tos;
                        r_cnt     <= w_steps;
                        r_dbz     <= w_dbz;
                        r_bad     <= w_bad;
                        if (w_steps == '0) begin
                            // Zero-step ops (div by zero, illegal, shift by 0) finish at once
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            if (w_bad) begin
                                r_lo <= '0;
                                r_hi <= '0;
                            end else if (w_dbz) begin
                                r_lo <= '1;
                                r_hi <= nos;
                            end else begin
                                r_lo <= nos;
                                r_hi <= '0;
                            end
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_acc <= w_acc;
                        r_q   <= w_q;
                        r_cnt <= r_cnt - c_ONE;
                        if (r_cnt == c_ONE) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_lo    <= w_q;
                            r_hi    <= w_acc;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result_lo   = r_lo;
    assign result_hi   = r_hi;
    assign div_by_zero = r_dbz;
    assign bad_op      = r_bad;

endmodule
`default_nettype wire

// File: doc/tos_mdu.md
Name: tos_mdu

Overview:
- Iterative multiply/divide/shift unit for the stack CPU's TOS datapath. It sits beside the single-cycle TOS ALU.
- The sequencer starts it with TOS/NOS operands, stalls while busy is high, and writes result_lo/result_hi back to NOS/TOS when done pulses.
- It adds the multi-cycle operations that the single-cycle TOS ALU lacks: UM*, UM/MOD, and N-bit shifts, all parametrised in width.

Parameters:
- WIDTH, 16, datapath width. Must be a power of two and at least 4.
- SHW, $clog2(WIDTH), width of the shift count (derived; not overridden).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request a new operation; sampled on the rising edge
- abort  in  1  synchronous cancel of the operation in flight
- op  in  3  operation code; sampled with start
- tos  in  WIDTH  top of stack: multiplier, divisor, or shift count (only tos[SHW-1:0] is used)
- nos  in  WIDTH  next on stack: multiplicand, dividend, or shift value
- busy  out  1  operation in progress; start is ignored while high
- done  out  1  one-cycle pulse; results are valid from this cycle
- result_lo  out  WIDTH  low product, quotient, or shifted value
- result_hi  out  WIDTH  high product, remainder, or 0
- div_by_zero  out  1  valid with done
- bad_op  out  1  valid with done

Behaviour:
- Clock and reset: clk; reset is asynchronous and active-high. Reset forces state IDLE and clears busy, done, result_lo, result_hi, div_by_zero, bad_op and all internal registers to 0. Reset mid-operation discards the operation with no done.
- Op codes:
  - 000 UMUL: unsigned nos*tos, 2*WIDTH-bit result.
  - 001 UDIVMOD: unsigned nos/tos, restoring division.
  - 010 LSL: logical shift left.
  - 011 LSR: logical shift right.
  - 100 ASR: arithmetic shift right.
  - 101-111: illegal.
- States: IDLE, RUN, DONE.
- Accept: start=1 and abort=0 in IDLE or DONE. Operands and op are latched, and the step counter is loaded with steps:
  - WIDTH for UMUL and UDIVMOD.
  - tos[SHW-1:0] for shifts.
  - 0 for divide-by-zero and illegal ops.
- Transitions:
  - If steps>0, go to RUN and assert busy from the next cycle.
  - If steps=0, go directly to DONE.
- RUN: one step per cycle; the counter decrements each step. After the last step, go to DONE.
- Latency: done is high exactly steps+1 cycles after the accepting edge (cycle 0 = accept edge).
- DONE:
  - done=1 and busy=0 for one cycle, then IDLE.
  - result_lo, result_hi and the flags hold their values until the next accept.
  - The flags are cleared at accept.
- UMUL: shift-add, LSB first.
  - Accumulator is WIDTH+1 bits so the carry is kept.
  - result_hi:result_lo = full product; no overflow is possible.
- UDIVMOD: restoring division.
  - result_lo = quotient, result_hi = remainder.
  - tos=0: result_lo = all ones, result_hi = nos, div_by_zero=1.
- Shifts: one bit per step.
  - result_hi = 0.
  - Count 0 returns nos unchanged.
  - ASR replicates the MSB.
  - Shift count wraps modulo WIDTH.
- Illegal op: results are 0 and bad_op=1.
- Handshake and boundary rules:
  - start while busy (RUN) is ignored. It is not queued.
  - abort in RUN: go to IDLE next cycle. busy drops, no done is generated, and results keep their previous values.
  - abort in IDLE/DONE: no effect except that it blocks any start in the same cycle.
  - Simultaneous start and abort: abort wins.
  - start in the DONE cycle is accepted, which allows back-to-back operations.
  - Operand inputs may change after accept without affecting the result.

Decomposition:
- Shared package tos_mdu_pkg:
  - op code localparams (OP_UMUL, OP_UDIVMOD, OP_LSL, OP_LSR, OP_ASR).
  - state encoding for IDLE/RUN/DONE.
- One sub-module, tos_mdu_step. It is purely combinational and computes one iteration (add/subtract/shift) from {acc, q, operand, op}.
- tos_mdu holds the FSM, the counter and the registers, and instantiates tos_mdu_step once.

Test Plan (WIDTH=16):
- UMUL: nos=0xFFFF, tos=0xFFFF, start at cycle 0 -> busy for cycles 1-16, done at cycle 17, result_hi=0xFFFE, result_lo=0x0001.
- UDIVMOD: nos=100, tos=7 -> done at cycle 17, result_lo=14, result_hi=2, div_by_zero=0. Repeat with nos=0x1234, tos=0 -> done at cycle 1, result_lo=0xFFFF, result_hi=0x1234, div_by_zero=1.
- ASR: nos=0x8000, tos=3 -> done at cycle 4, result_lo=0xF000. LSL with tos=0x0013 (count 3) and nos=0x0001 -> result_lo=0x0008. LSR with tos=0 -> done at cycle 1, result_lo=nos.
- Abort:
  - UMUL started, then abort at cycle 5 -> busy=0 at cycle 6, no done, results unchanged.
  - start+abort in the same cycle -> ignored.
  - start during RUN -> ignored, original result unaffected.
- Back-to-back: start a new LSR in the DONE cycle of a UMUL -> UMUL results are seen during done, then the LSR completes with correct latency. op=111 -> done at cycle 1, bad_op=1, results 0.
- Reset: assert reset asynchronously mid-UDIVMOD -> all outputs 0 immediately, IDLE. A following UMUL 3*5 -> result_lo=15, result_hi=0 at cycle 17.
